uart_rx_fifo_ctrl: RTL and testbench

Receive-side controller for the 16550-style UART. It sits between the receiver core and the register/bus interface and does four things:
- buffers each character (with its per-character error flags) that the receiver core pushes;
- produces the line-status bits DR, OE, PE/FE/BI-at-head and FIFO-error;
- raises the received-data-available interrupt on the FCR trigger level;
- raises the character-timeout interrupt, timed on the 16x baud tick.

---
 rtl/uart_pkg.sv | 41 ++++
 rtl/uart_rx_timeout.sv | 36 +++
 rtl/uart_rx_fifo_ctrl.sv | 168 ++++++++++++++++
 tb/tb_uart_rx_fifo_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the 16550-style UART receive path.
//   RX_FIFO_DEPTH - default receive FIFO depth
//   trig_lvl_e    - FCR[7:6] receive trigger level encoding
//   rx_entry_t    - one stored character with its PE/FE/BI flags
//   trig_count()  - trigger level -> entry count (1/4/8/14)
//   char_bits()   - bits per character: start + data + parity + stop
package uart_pkg;

   localparam int unsigned RX_FIFO_DEPTH = 16;

   typedef enum logic [1:0] {
      TRIG_1  = 2'b00,
      TRIG_4  = 2'b01,
      TRIG_8  = 2'b10,
      TRIG_14 = 2'b11
   } trig_lvl_e;

   typedef struct packed {
      logic       bi;
      logic       fe;
      logic       pe;
      logic [7:0] data;
   } rx_entry_t;

   function automatic logic [4:0] trig_count(trig_lvl_e t);
      logic [4:0] n;
      case (t)
         TRIG_1:  n = 5'd1;
         TRIG_4:  n = 5'd4;
         TRIG_8:  n = 5'd8;
         default: n = 5'd14;
      endcase
      return n;
   endfunction

   // 1 start + (5+wls) data + pen parity + (1 or 2) stop = 7 + wls + pen + stb
   function automatic logic [3:0] char_bits(logic [1:0] wls, logic stb, logic pen);
      return 4'd7 + {2'b00, wls} + {3'b000, pen} + {3'b000, stb};
   endfunction

endpackage

// File: rtl/uart_rx_timeout.sv
// uart_rx_timeout: character-timeout counter for the receive FIFO.
//   clk, rst       - clock, synchronous active-low reset
//   baud_pulse     - 16x oversample tick
//   restart        - clears the counter this cycle
//   nonempty       - FIFO holds data (and timeout is enabled)
//   char_bits      - bits per character (7..12)
//   cto_irq        - counter has reached four character times
module uart_rx_timeout (
   input  logic       clk,
   input  logic       rst,
   input  logic       baud_pulse,
   input  logic       restart,
   input  logic       nonempty,
   input  logic [3:0] char_bits,
   output logic       cto_irq
);

   logic [9:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (restart)
         cnt_d = '0;
      else if (baud_pulse && (cnt_q != '1))
         cnt_d = cnt_q + 10'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

   // 4 char times of 16 ticks each = char_bits * 64
   assign cto_irq = nonempty && (cnt_q >= {char_bits, 6'd0});

endmodule

// File: rtl/uart_rx_fifo_ctrl.sv
// uart_rx_fifo_ctrl: receive FIFO, line status and RX interrupts for a 16550-style UART.
//   clk, rst                 - clock, synchronous active-low reset
//   baud_pulse               - 16x oversample tick
//   push, din, din_pe/fe/bi  - character from receiver core with error flags
//   wls, stb, pen            - line format, used for the character time
//   fifo_en, fifo_clr        - FCR[0], FCR[1] strobe
//   trig_lvl                 - FCR[7:6]
//   pop, lsr_rd              - RBR / LSR read strobes
//   dout, dout_pe/fe/bi      - head entry (zero while empty)
//   dr, full, count          - FIFO status
//   overrun, fifo_err        - LSR OE and LSR bit7
//   rda_irq, cto_irq         - receive-data-available and character-timeout
// Optional: define UART_RX_FIFO_STATS_EN for stat_rx_chars / stat_rx_errs counters.
module uart_rx_fifo_ctrl
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH = RX_FIFO_DEPTH,
   parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             baud_pulse,
   input  logic             push,
   input  logic [7:0]       din,
   input  logic             din_pe,
   input  logic             din_fe,
   input  logic             din_bi,
   input  logic [1:0]       wls,
   input  logic             stb,
   input  logic             pen,
   input  logic             fifo_en,
   input  logic             fifo_clr,
   input  logic [1:0]       trig_lvl,
   input  logic             pop,
   input  logic             lsr_rd,
   output logic [7:0]       dout,
   output logic             dout_pe,
   output logic             dout_fe,
   output logic             dout_bi,
   output logic             dr,
   output logic             full,
   output logic [CNT_W-1:0] count,
   output logic             overrun,
   output logic             fifo_err,
   output logic             rda_irq,
`ifdef UART_RX_FIFO_STATS_EN
   output logic [15:0]      stat_rx_chars,
   output logic [15:0]      stat_rx_errs,
`endif
   output logic             cto_irq
);

   localparam int unsigned PW = $clog2(DEPTH);

   rx_entry_t        mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d, err_cnt_q, err_cnt_d;
   logic             overrun_q, overrun_d, rda_q, rda_d, fifo_en_q;
   logic             empty, full_w, flush, pop_acc, push_acc, ovr_evt;
   logic             din_err, head_err, to_nonempty, to_restart;
   logic [CNT_W-1:0] eff_depth, trig_cnt;
   rx_entry_t        din_ent, head;

   assign empty     = (count_q == '0);
   assign eff_depth = fifo_en ? CNT_W'(DEPTH) : CNT_W'(1);
   assign full_w    = (count_q == eff_depth);
   assign trig_cnt  = fifo_en ? CNT_W'(trig_count(trig_lvl_e'(trig_lvl))) : CNT_W'(1);
   // a mode change behaves exactly like an FCR clear
   assign flush     = fifo_clr | (fifo_en ^ fifo_en_q);
   assign pop_acc   = pop & ~empty & ~flush;
   // when full, a simultaneous pop frees the slot being written
   assign push_acc  = push & ~flush & (~full_w | pop_acc);
   assign ovr_evt   = push & ~flush & full_w & ~pop_acc;

   assign din_ent   = '{bi: din_bi, fe: din_fe, pe: din_pe, data: din};
   assign head      = mem_q[rd_ptr_q];
   assign din_err   = din_bi | din_fe | din_pe;
   assign head_err  = head.bi | head.fe | head.pe;

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      err_cnt_d = err_cnt_q;
      if (flush) begin
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         count_d   = '0;
         err_cnt_d = '0;
      end else begin
         if (push_acc) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop_acc)  rd_ptr_d = rd_ptr_q + PW'(1);
         count_d   = count_q + CNT_W'(push_acc) - CNT_W'(pop_acc);
         err_cnt_d = err_cnt_q + CNT_W'(push_acc & din_err) - CNT_W'(pop_acc & head_err);
      end
      // a fresh overrun wins over a clearing LSR read
      overrun_d = ovr_evt | (overrun_q & ~lsr_rd);
      rda_d     = (count_q >= trig_cnt);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         err_cnt_q <= '0;
         overrun_q <= 1'b0;
         rda_q     <= 1'b0;
         fifo_en_q <= fifo_en;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         err_cnt_q <= err_cnt_d;
         overrun_q <= overrun_d;
         rda_q     <= rda_d;
         fifo_en_q <= fifo_en;
      end
   end

   always_ff @(posedge clk) begin
      if (push_acc) mem_q[wr_ptr_q] <= din_ent;
   end

   assign to_nonempty = ~empty & fifo_en;
   assign to_restart  = push_acc | pop | flush | ~to_nonempty;

   uart_rx_timeout u_timeout (
      .clk        (clk),
      .rst        (rst),
      .baud_pulse (baud_pulse),
      .restart    (to_restart),
      .nonempty   (to_nonempty),
      .char_bits  (char_bits(wls, stb, pen)),
      .cto_irq    (cto_irq)
   );

`ifdef UART_RX_FIFO_STATS_EN
   logic [15:0] chars_q, errs_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         chars_q <= '0;
         errs_q  <= '0;
      end else begin
         if (push_acc && (chars_q != '1))
            chars_q <= chars_q + 16'd1;
         if (((push_acc & din_err) | ovr_evt) && (errs_q != '1))
            errs_q <= errs_q + 16'd1;
      end
   end

   assign stat_rx_chars = chars_q;
   assign stat_rx_errs  = errs_q;
`endif

   assign dout     = empty ? '0 : head.data;
   assign dout_pe  = ~empty & head.pe;
   assign dout_fe  = ~empty & head.fe;
   assign dout_bi  = ~empty & head.bi;
   assign dr       = ~empty;
   assign full     = full_w;
   assign count    = count_q;
   assign overrun  = overrun_q;
   assign fifo_err = (err_cnt_q != '0);
   assign rda_irq  = rda_q;

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
module tb_uart_rx_fifo_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       baud_pulse = 1'b0;
   logic       push = 1'b0;
   logic [7:0] din = '0;
   logic       din_pe = 1'b0, din_fe = 1'b0, din_bi = 1'b0;
   logic [1:0] wls = 2'b11;
   logic       stb = 1'b0, pen = 1'b0;
   logic       fifo_en = 1'b1, fifo_clr = 1'b0;
   logic [1:0] trig_lvl = 2'b00;
   logic       pop = 1'b0, lsr_rd = 1'b0;

   logic [7:0] dout;
   logic       dout_pe, dout_fe, dout_bi, dr, full, overrun, fifo_err, rda_irq, cto_irq;
   logic [4:0] count;
`ifdef UART_RX_FIFO_STATS_EN
   logic [15:0] stat_rx_chars, stat_rx_errs;
   int unsigned m_chars = 0, m_errs = 0;
`endif

   uart_rx_fifo_ctrl #(.DEPTH(16), .CNT_W(5)) dut (
      .clk(clk), .rst(rst), .baud_pulse(baud_pulse), .push(push), .din(din),
      .din_pe(din_pe), .din_fe(din_fe), .din_bi(din_bi), .wls(wls), .stb(stb), .pen(pen),
      .fifo_en(fifo_en), .fifo_clr(fifo_clr), .trig_lvl(trig_lvl), .pop(pop), .lsr_rd(lsr_rd),
      .dout(dout), .dout_pe(dout_pe), .dout_fe(dout_fe), .dout_bi(dout_bi), .dr(dr),
      .full(full), .count(count), .overrun(overrun), .fifo_err(fifo_err), .rda_irq(rda_irq),
`ifdef UART_RX_FIFO_STATS_EN
      .stat_rx_chars(stat_rx_chars), .stat_rx_errs(stat_rx_errs),
`endif
      .cto_irq(cto_irq)
   );

   always #5 clk = ~clk;

   int unsigned nerr = 0, nchk = 0;

   // reference model: a queue of {bi,fe,pe,data} plus a few scalars
   logic [10:0] mq[$];
   bit          m_ovr = 0, m_rda = 0, m_fen_prev = 1;
   int unsigned m_tcnt = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      nchk++;
      assert (obs === expv)
      else begin
         nerr++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   task automatic model_update();
      int unsigned n, cap, trig;
      bit flush, dpop, dpush, oev, restart, ferr;
      if (!rst) begin
         mq.delete();
         m_ovr = 0; m_rda = 0; m_tcnt = 0; m_fen_prev = fifo_en;
`ifdef UART_RX_FIFO_STATS_EN
         m_chars = 0; m_errs = 0;
`endif
         return;
      end
      n     = mq.size();
      cap   = fifo_en ? 16 : 1;
      trig  = !fifo_en ? 1 : (trig_lvl == 0 ? 1 : trig_lvl == 1 ? 4 : trig_lvl == 2 ? 8 : 14);
      flush = fifo_clr || (fifo_en != m_fen_prev);
      dpop  = pop && n > 0 && !flush;
      dpush = push && !flush && (n < cap || dpop);
      oev   = push && !flush && n >= cap && !dpop;
      ferr  = din_pe || din_fe || din_bi;
      restart = flush || dpush || pop || n == 0 || !fifo_en;
      if (restart) m_tcnt = 0;
      else if (baud_pulse && m_tcnt < 1023) m_tcnt++;
      m_rda = (n >= trig);
      if (flush) mq.delete();
      else begin
         if (dpop) void'(mq.pop_front());
         if (dpush) mq.push_back({din_bi, din_fe, din_pe, din});
      end
      m_ovr = oev ? 1'b1 : (lsr_rd ? 1'b0 : m_ovr);
`ifdef UART_RX_FIFO_STATS_EN
      if (dpush && m_chars < 65535) m_chars++;
      if (((dpush && ferr) || oev) && m_errs < 65535) m_errs++;
`endif
      m_fen_prev = fifo_en;
   endtask

   task automatic check_all();
      logic [10:0] h;
      int unsigned n, cb;
      bit anyerr;
      n = mq.size();
      h = (n > 0) ? mq[0] : 11'h0;
      anyerr = 0;
      foreach (mq[i]) if (mq[i][10:8] != 3'b000) anyerr = 1;
      cb = 7 + wls + pen + stb;
      chk("dout",     dout,     h[7:0]);
      chk("dout_pe",  dout_pe,  h[8]);
      chk("dout_fe",  dout_fe,  h[9]);
      chk("dout_bi",  dout_bi,  h[10]);
      chk("dr",       dr,       n > 0);
      chk("full",     full,     n == (fifo_en ? 16 : 1));
      chk("count",    count,    n);
      chk("overrun",  overrun,  m_ovr);
      chk("fifo_err", fifo_err, anyerr);
      chk("rda_irq",  rda_irq,  m_rda);
      chk("cto_irq",  cto_irq,  fifo_en && n > 0 && m_tcnt >= 64 * cb);
`ifdef UART_RX_FIFO_STATS_EN
      chk("stat_chars", stat_rx_chars, m_chars);
      chk("stat_errs",  stat_rx_errs,  m_errs);
`endif
   endtask

   // one clock: model follows the edge, outputs checked 1 time unit later, strobes dropped
   task automatic cyc();
      @(posedge clk);
      model_update();
      #1;
      check_all();
      push = 0; pop = 0; fifo_clr = 0; lsr_rd = 0; baud_pulse = 0;
      din_pe = 0; din_fe = 0; din_bi = 0;
   endtask

   initial begin
      // reset
      #1;
      cyc(); cyc();
      chk("reset_count", count, 0);
      chk("reset_dr", dr, 0);
      rst = 1;
      cyc();

      // fill to trigger level 8, then drain in order
      trig_lvl = 2'b10;
      for (int i = 0; i < 8; i++) begin
         push = 1; din = 8'h41 + 8'(i); cyc();
      end
      chk("fill_count8", count, 8);
      chk("fill_rda_lag", rda_irq, 0);
      cyc();
      chk("fill_rda", rda_irq, 1);
      chk("fill_head", dout, 8'h41);
      for (int i = 0; i < 8; i++) begin
         chk("pop_order", dout, 8'h41 + 8'(i));
         pop = 1; cyc();
      end
      chk("drained", dr, 0);

      // overrun on the 17th character
      for (int i = 0; i < 17; i++) begin
         push = 1; din = 8'(i + 1); cyc();
         if (i == 15) chk("full16", full, 1);
      end
      chk("ovr_set", overrun, 1);
      chk("ovr_count", count, 16);
      lsr_rd = 1; cyc();
      chk("ovr_clr", overrun, 0);
      chk("ovr_head", dout, 8'h01);

      // push+pop while full, then clear racing a push
      push = 1; pop = 1; din = 8'hEE; cyc();
      chk("pp_count", count, 16);
      chk("pp_no_ovr", overrun, 0);
      fifo_clr = 1; push = 1; din = 8'h77; cyc();
      chk("clr_count", count, 0);
      chk("clr_dr", dr, 0);
      chk("clr_no_ovr", overrun, 0);

      // error flags
      push = 1; din = 8'h45; din_pe = 1; cyc();
      push = 1; din = 8'h46; cyc();
      chk("err_set", fifo_err, 1);
      chk("err_head_pe", dout_pe, 1);
      pop = 1; cyc();
      chk("err_clr", fifo_err, 0);
      pop = 1; cyc();

      // character timeout: 11-bit frame -> 704 ticks
      wls = 2'b11; pen = 1; stb = 0;
      push = 1; din = 8'h5A; cyc();
      for (int i = 0; i < 703; i++) begin
         baud_pulse = 1; cyc();
      end
      chk("cto_703", cto_irq, 0);
      baud_pulse = 1; cyc();
      chk("cto_704", cto_irq, 1);
      pop = 1; cyc();
      chk("cto_pop", cto_irq, 0);

      // randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         push       = ($urandom_range(0, 99) < 45);
         pop        = ($urandom_range(0, 99) < 35);
         lsr_rd     = ($urandom_range(0, 99) < 10);
         baud_pulse = ($urandom_range(0, 99) < 70);
         fifo_clr   = ($urandom_range(0, 99) < 2);
         din_pe     = ($urandom_range(0, 99) < 10);
         din_fe     = ($urandom_range(0, 99) < 5);
         din_bi     = ($urandom_range(0, 99) < 5);
         if ($urandom_range(0, 99) < 5) trig_lvl = 2'($urandom);
         if ($urandom_range(0, 99) < 2) begin
            wls = 2'($urandom); pen = 1'($urandom); stb = 1'($urandom);
         end
         if ($urandom_range(0, 199) == 0) fifo_en = ~fifo_en;
         din = 8'($urandom) & (8'hFF >> (3 - wls));
         cyc();
      end

      // holding-register mode
      fifo_en = 0; cyc();
      fifo_clr = 1; cyc();
      push = 1; din = 8'h55; cyc();
      push = 1; din = 8'hAA; cyc();
      chk("nf_ovr", overrun, 1);
      chk("nf_head", dout, 8'h55);
      chk("nf_count", count, 1);
      chk("nf_rda", rda_irq, 1);
      for (int i = 0; i < 800; i++) begin
         baud_pulse = 1; cyc();
      end
      chk("nf_cto", cto_irq, 0);

      // reset mid-stream
      rst = 0; cyc();
      chk("rst_dr", dr, 0);
      chk("rst_ovr", overrun, 0);
      chk("rst_rda", rda_irq, 0);
      chk("rst_dout", dout, 0);
      rst = 1; fifo_en = 1; cyc();
      cyc();

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
